// File: rtl/decoder_index_sequencer_pkg.sv
// Shared constants for the decoder index sequencer.
// Contains the step-mode codes and the FSM state encoding.
package seq_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_SWEEP    = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/decoder_index_sequencer_if.sv
// Control and decoder-side signals of the index sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface decoder_index_sequencer_if;

  logic       run;
  logic       dir;
  logic [1:0] mode;
  logic       step_req;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] a;
  logic       EN;
  logic       tick;
  logic       sweep_done;

  modport master (
    output run, dir, mode, step_req, load, load_val,
    input  a, EN, tick, sweep_done
  );

  modport slave (
    input  run, dir, mode, step_req, load, load_val,
    output a, EN, tick, sweep_done
  );

endinterface

// File: rtl/decoder_index_sequencer_tick_prescaler.sv
// Free-running divide-by-TICK_DIV prescaler producing a one-cycle tick.
// The terminal count is detected one cycle early so tick comes straight from a flop.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Prescaler count and registered terminal-count pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else if (clr || !en) begin
      cnt_r  <= CNT_ZERO;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
      tick_r <= (cnt_r == CNT_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/decoder_index_sequencer.sv
// Index generator feeding the 4-to-16 decoder: FSM, index and ping-pong direction.
// Steps a[3:0] on each prescaler tick in wrap, ping-pong, sweep or hold mode.
module decoder_index_sequencer
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input logic                         clk,
  input logic                         rst_n,
  decoder_index_sequencer_if.slave    bus
);

  seq_state_t state_r, state_s;
  logic [3:0] a_r, a_s;
  logic [3:0] tgt_s;
  logic [1:0] mode_last_r, mode_last_s;
  logic       pp_down_r, pp_down_s, pp_dir_s;
  logic       en_r, sweep_done_r, done_s, adv_s;
  logic       tick_s, clr_s;

  // The prescaler restarts on every state change and on load
  assign clr_s = bus.load | (state_s != state_r);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_r == ST_RUN),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next-state, next-index and ping-pong direction
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    pp_down_s   = pp_down_r;
    mode_last_s = mode_last_r;
    pp_dir_s    = pp_down_r;
    tgt_s       = 4'd15;
    done_s      = 1'b0;
    adv_s       = 1'b0;

    unique case (state_r)
      ST_IDLE: begin
        if (bus.run) state_s = ST_RUN;
        else         adv_s   = bus.step_req;
      end
      ST_RUN: begin
        adv_s = tick_s;
        if (!bus.run) state_s = ST_IDLE;
        else          state_s = ST_RUN;
      end
      ST_DONE: begin
        if (!bus.run) state_s = ST_IDLE;
        else          state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase

    if (adv_s) begin
      mode_last_s = bus.mode;
      case (bus.mode)
        MODE_WRAP: a_s = bus.dir ? a_r - 4'd1 : a_r + 4'd1;
        MODE_PINGPONG: begin
          // Entering ping-pong picks up the external direction
          pp_dir_s = (mode_last_r != MODE_PINGPONG) ? bus.dir : pp_down_r;
          if (pp_dir_s) begin
            if (a_r == 4'd0) begin
              a_s       = 4'd1;
              pp_down_s = 1'b0;
            end else begin
              a_s       = a_r - 4'd1;
              pp_down_s = 1'b1;
            end
          end else begin
            if (a_r == 4'd15) begin
              a_s       = 4'd14;
              pp_down_s = 1'b1;
            end else begin
              a_s       = a_r + 4'd1;
              pp_down_s = 1'b0;
            end
          end
        end
        MODE_SWEEP: begin
          tgt_s = bus.dir ? 4'd0 : 4'd15;
          if (a_r != tgt_s) a_s = bus.dir ? a_r - 4'd1 : a_r + 4'd1;
          else              a_s = a_r;
          if ((a_s == tgt_s) && (state_r == ST_RUN) && bus.run) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            done_s  = 1'b0;
          end
        end
        MODE_HOLD: a_s = a_r;
        default:   a_s = a_r;
      endcase
    end else begin
      mode_last_s = mode_last_r;
    end

    if (bus.load) begin
      a_s         = bus.load_val;
      pp_down_s   = bus.dir;
      mode_last_s = bus.mode;
      state_s     = state_r;
      done_s      = 1'b0;
    end else begin
      pp_dir_s    = pp_dir_s;
    end
  end

  // State, index and registered decoder outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      a_r          <= 4'd0;
      pp_down_r    <= 1'b0;
      mode_last_r  <= MODE_WRAP;
      en_r         <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      a_r          <= a_s;
      pp_down_r    <= pp_down_s;
      mode_last_r  <= mode_last_s;
      en_r         <= (state_s != ST_IDLE);
      sweep_done_r <= done_s;
    end
  end

  assign bus.a          = a_r;
  assign bus.EN         = en_r;
  assign bus.tick       = tick_s;
  assign bus.sweep_done = sweep_done_r;

endmodule

// File: tb/tb_decoder_index_sequencer.sv
// Directed self-checking bench for decoder_index_sequencer with TICK_DIV=4.
module tb_decoder_index_sequencer;
  import seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  int   exp_a;

  decoder_index_sequencer_if bus ();

  decoder_index_sequencer #(
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run = n_run + 1;
    if (obs != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.run = 1'b0; bus.dir = 1'b0; bus.mode = MODE_WRAP;
    bus.step_req = 1'b0; bus.load = 1'b0; bus.load_val = 4'd0;
    #12;
    chk("rst_a", int'(bus.a), 0);
    chk("rst_en", int'(bus.EN), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_done", int'(bus.sweep_done), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // wrap up
    bus.run = 1'b1;
    cyc();
    chk("wrap_en", int'(bus.EN), 1);
    chk("wrap_a0", int'(bus.a), 0);
    repeat (2) cyc();
    chk("wrap_notick", int'(bus.tick), 0);
    cyc();
    chk("wrap_tick", int'(bus.tick), 1);
    chk("wrap_a_tick", int'(bus.a), 0);
    cyc();
    chk("wrap_a1", int'(bus.a), 1);
    for (int k = 2; k <= 16; k++) begin
      repeat (4) cyc();
      chk("wrap_seq", int'(bus.a), k % 16);
    end

    // pause two cycles before a tick, then resume
    cyc();
    bus.run = 1'b0;
    cyc();
    chk("pause_en", int'(bus.EN), 0);
    repeat (3) cyc();
    chk("pause_a", int'(bus.a), 0);
    chk("pause_tick", int'(bus.tick), 0);
    bus.run = 1'b1;
    cyc();
    chk("resume_en", int'(bus.EN), 1);
    repeat (2) cyc();
    chk("resume_notick", int'(bus.tick), 0);
    cyc();
    chk("resume_tick", int'(bus.tick), 1);
    cyc();
    chk("resume_a", int'(bus.a), 1);
    bus.run = 1'b0;
    cyc();

    // idle step downward wraps 0 -> 15
    bus.load = 1'b1; bus.load_val = 4'd0;
    cyc();
    bus.load = 1'b0;
    chk("idle_load", int'(bus.a), 0);
    bus.mode = MODE_WRAP; bus.dir = 1'b1; bus.step_req = 1'b1;
    cyc();
    bus.step_req = 1'b0;
    chk("step_a", int'(bus.a), 15);
    chk("step_en", int'(bus.EN), 0);

    // ping-pong from 14
    bus.load = 1'b1; bus.load_val = 4'd14; bus.mode = MODE_PINGPONG; bus.dir = 1'b0;
    cyc();
    bus.load = 1'b0;
    chk("pp_load", int'(bus.a), 14);
    bus.run = 1'b1;
    cyc();
    for (int k = 1; k <= 17; k++) begin
      repeat (4) cyc();
      exp_a = (k == 1) ? 15 : ((k <= 16) ? 16 - k : 1);
      chk("pp_seq", int'(bus.a), exp_a);
    end
    bus.run = 1'b0;
    cyc();

    // load on a tick cycle discards that advance
    bus.mode = MODE_WRAP; bus.dir = 1'b0; bus.run = 1'b1;
    cyc();
    repeat (3) cyc();
    chk("ld_tick", int'(bus.tick), 1);
    bus.load = 1'b1; bus.load_val = 4'd9;
    cyc();
    bus.load = 1'b0;
    chk("ld_a", int'(bus.a), 9);
    repeat (3) cyc();
    chk("ld_tick2", int'(bus.tick), 1);
    chk("ld_hold", int'(bus.a), 9);
    cyc();
    chk("ld_next", int'(bus.a), 10);
    bus.run = 1'b0;
    cyc();

    // single-shot sweep down from 2
    bus.load = 1'b1; bus.load_val = 4'd2; bus.mode = MODE_SWEEP; bus.dir = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.run = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("sw_a1", int'(bus.a), 1);
    chk("sw_nodone", int'(bus.sweep_done), 0);
    repeat (4) cyc();
    chk("sw_a0", int'(bus.a), 0);
    chk("sw_done", int'(bus.sweep_done), 1);
    chk("sw_en", int'(bus.EN), 1);
    cyc();
    chk("sw_done_pulse", int'(bus.sweep_done), 0);
    repeat (5) cyc();
    chk("sw_hold_a", int'(bus.a), 0);
    chk("sw_hold_en", int'(bus.EN), 1);
    chk("sw_hold_done", int'(bus.sweep_done), 0);
    bus.run = 1'b0;
    cyc();
    chk("sw_stop_en", int'(bus.EN), 0);
    chk("sw_stop_a", int'(bus.a), 0);

    // asynchronous reset in the middle of RUN
    bus.mode = MODE_WRAP; bus.dir = 1'b0; bus.run = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("ar_a_pre", int'(bus.a), 1);
    repeat (3) cyc();
    chk("ar_tick_pre", int'(bus.tick), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_a", int'(bus.a), 0);
    chk("ar_en", int'(bus.EN), 0);
    chk("ar_tick", int'(bus.tick), 0);
    chk("ar_done", int'(bus.sweep_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
